// File: rtl/coef_load_ctrl.sv
// coef_load_ctrl
//   Loads FIR coefficients from deserialized SPI packets into the shadow
//   coefficient bank. A commit is accepted only after every tap has been
//   written. The bank swap waits for the next FIR sample boundary, so the
//   datapath never sees a half-updated coefficient set.
//
// Ports
//   Clk, Reset     : single clock, asynchronous active-high reset
//   Pkt_Data       : 32-bit packet {hdr[31:24], op[23:21], addr[20:16], data}
//   Pkt_Valid      : one-cycle strobe qualifying Pkt_Data
//   Sample_Strobe  : one-cycle FIR sample boundary pulse
//   Coef_Wr_*      : registered write port into the shadow bank
//   Bank_Sel       : active bank read by the FIR datapath
//   Filt_En        : FIR output enable, set by the first completed swap
//   Load_Busy      : a load or a pending swap is in progress
//   Err_Count      : saturating count of rejected packets
module coef_load_ctrl #(
  parameter int         NUM_TAPS = 32,
  parameter int         COEF_W   = 12,
  parameter logic [7:0] HDR      = 8'hFB
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [31:0]       Pkt_Data,
  input  logic              Pkt_Valid,
  input  logic              Sample_Strobe,
  output logic              Coef_Wr_En,
  output logic              Coef_Wr_Bank,
  output logic [4:0]        Coef_Wr_Addr,
  output logic [COEF_W-1:0] Coef_Wr_Data,
  output logic              Bank_Sel,
  output logic              Filt_En,
  output logic              Load_Busy,
  output logic [7:0]        Err_Count
);

  localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  localparam logic [2:0] OP_WRITE  = 3'b000;
  localparam logic [2:0] OP_COMMIT = 3'b001;
  localparam logic [2:0] OP_ABORT  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT_WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_TAPS-1:0] mask_q, mask_d;
  logic                bank_sel_q, bank_sel_d;
  logic                filt_en_q, filt_en_d;
  logic                wr_en_q, wr_en_d;
  logic [4:0]          wr_addr_q, wr_addr_d;
  logic [COEF_W-1:0]   wr_data_q, wr_data_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic                hdr_ok;
  logic [2:0]          pkt_op;
  logic [4:0]          pkt_addr;
  logic                addr_ok;
  logic                reject;
  logic                abort_hit;
  logic                unused_bits;

  assign hdr_ok   = (Pkt_Data[31:24] == HDR);
  assign pkt_op   = Pkt_Data[23:21];
  assign pkt_addr = Pkt_Data[20:16];
  assign addr_ok  = ({1'b0, pkt_addr} < 6'(NUM_TAPS));
  // Bits [15:COEF_W] of the packet carry no information.
  assign unused_bits = ^Pkt_Data[15:0];

  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    bank_sel_d = bank_sel_q;
    filt_en_d  = filt_en_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    err_cnt_d  = err_cnt_q;
    reject     = 1'b0;
    abort_hit  = 1'b0;

    if (Pkt_Valid) begin
      if (!hdr_ok) begin
        reject = 1'b1;
      end else begin
        case (pkt_op)
          OP_WRITE: begin
            // The shadow bank is frozen once a commit is pending.
            if (state_q == S_COMMIT_WAIT || !addr_ok) begin
              reject = 1'b1;
            end else begin
              wr_en_d                = 1'b1;
              wr_addr_d              = pkt_addr;
              wr_data_d              = Pkt_Data[COEF_W-1:0];
              mask_d[pkt_addr[AW-1:0]] = 1'b1;
              state_d                = S_LOAD;
            end
          end
          OP_COMMIT: begin
            if (state_q == S_LOAD && (&mask_q)) begin
              state_d = S_COMMIT_WAIT;
            end else begin
              reject = 1'b1;
            end
          end
          OP_ABORT: begin
            if (state_q != S_IDLE) begin
              abort_hit = 1'b1;
              mask_d    = '0;
              state_d   = S_IDLE;
            end
          end
          default: reject = 1'b1;
        endcase
      end
    end

    // Uses the registered state, so a strobe coinciding with the COMMIT
    // packet itself cannot complete the swap. An ABORT in the same cycle wins.
    if (state_q == S_COMMIT_WAIT && Sample_Strobe && !abort_hit) begin
      bank_sel_d = ~bank_sel_q;
      filt_en_d  = 1'b1;
      mask_d     = '0;
      state_d    = S_IDLE;
    end

    if (reject && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      bank_sel_q <= 1'b0;
      filt_en_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      bank_sel_q <= bank_sel_d;
      filt_en_q  <= filt_en_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Coef_Wr_En   = wr_en_q;
  assign Coef_Wr_Bank = ~bank_sel_q;
  assign Coef_Wr_Addr = wr_addr_q;
  assign Coef_Wr_Data = wr_data_q;
  assign Bank_Sel     = bank_sel_q;
  assign Filt_En      = filt_en_q;
  assign Load_Busy    = (state_q != S_IDLE);
  assign Err_Count    = err_cnt_q;

endmodule
